// File: rtl/fpdiv_seq_ctrl.sv
// fpdiv_seq_ctrl: sequencer and result packer for a Goldschmidt single-precision
// divider datapath. Operands arrive on a valid/ready port, the controller steps
// the datapath through the K0 step plus ITERS refinement iterations, then packs
// the 1.27 quotient from datapath register A into an IEEE single.
// Optional feature macro: SPECIAL_CASE_EN (zero/inf/NaN operand bypass).
module fpdiv_seq_ctrl #(
    parameter int ITERS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [31:0] dp_num,
    output logic [31:0] dp_denom,
    output logic        en_a,
    output logic        en_b,
    output logic        sel_mux2,
    output logic [1:0]  sel_mux4,
    input  logic [27:0] dp_rega
);

    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    typedef enum logic [2:0] {
        IDLE, INIT_N, INIT_D, ITER_N, ITER_D, PACK, DONE, SPECIAL
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic               sign;
    logic signed [9:0]  e;
    logic               accept;

    // Bits below single-precision mantissa resolution are dropped by truncation.
    logic               unused_guard;
    assign unused_guard = ^dp_rega[2:0];

    // Normalise the [0.5,2) quotient, then saturate to inf or flush to zero.
    function automatic logic [31:0] pack(input logic s, input logic signed [9:0] ex,
                                         input logic [27:0] q);
        logic signed [9:0] x;
        logic [22:0]       m;
        if (q[27]) begin
            m = q[26:4];
            x = ex;
        end else begin
            m = q[25:3];
            x = ex - 10'sd1;
        end
        if (x >= 10'sd255)
            pack = {s, 8'hFF, 23'h0};
        else if (x <= 10'sd0)
            pack = {s, 31'h0};
        else
            pack = {s, x[7:0], m};
    endfunction

`ifdef SPECIAL_CASE_EN
    // Special-operand kinds: 0 none, 1 NaN result, 2 infinity result, 3 zero result.
    logic [1:0] spec;

    function automatic logic [1:0] classify(input logic [31:0] x, input logic [31:0] y);
        logic x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
        x_zero = (x[30:23] == 8'h00);
        y_zero = (y[30:23] == 8'h00);
        x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
        y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'h0);
        x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
        y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'h0);
        if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf))
            classify = 2'd1;
        else if (y_zero || x_inf)
            classify = 2'd2;
        else if (x_zero || y_inf)
            classify = 2'd3;
        else
            classify = 2'd0;
    endfunction
`endif

    assign accept = in_valid && (state == IDLE);

    // Next state plus the combinational datapath enables/selects decoded from state.
    always_comb begin
        state_n  = state;
        in_ready = (state == IDLE);
        en_a     = 1'b0;
        en_b     = 1'b0;
        sel_mux2 = 1'b0;
        sel_mux4 = 2'b00;
        case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef SPECIAL_CASE_EN
                    state_n = (classify(a, b) != 2'd0) ? SPECIAL : INIT_N;
`else
                    state_n = INIT_N;
`endif
                end
            end
            INIT_N: begin
                en_a    = 1'b1;
                state_n = INIT_D;
            end
            INIT_D: begin
                sel_mux4 = 2'b01;
                en_b     = 1'b1;
                state_n  = ITER_N;
            end
            ITER_N: begin
                sel_mux2 = 1'b1;
                sel_mux4 = 2'b10;
                en_a     = 1'b1;
                state_n  = ITER_D;
            end
            ITER_D: begin
                sel_mux2 = 1'b1;
                sel_mux4 = 2'b11;
                en_b     = 1'b1;
                state_n  = (int'(cnt) < ITERS - 1) ? ITER_N : PACK;
            end
            // Special results share PACK so the result register has one load point.
            SPECIAL: state_n = PACK;
            PACK:    state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register, iteration count, operand capture and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            result    <= 32'h0;
            dp_num    <= 32'h0;
            dp_denom  <= 32'h0;
            sign      <= 1'b0;
            e         <= 10'sd0;
`ifdef SPECIAL_CASE_EN
            spec      <= 2'd0;
`endif
        end else begin
            state <= state_n;
            if (accept) begin
                dp_num   <= a;
                dp_denom <= b;
                sign     <= a[31] ^ b[31];
                e        <= $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
`ifdef SPECIAL_CASE_EN
                spec     <= classify(a, b);
`endif
            end
            if (state == INIT_D)
                cnt <= '0;
            else if (state == ITER_D && int'(cnt) < ITERS - 1)
                cnt <= cnt + 1'b1;
            if (state == PACK) begin
`ifdef SPECIAL_CASE_EN
                case (spec)
                    2'd1:    result <= 32'h7FC00000;
                    2'd2:    result <= {sign, 8'hFF, 23'h0};
                    2'd3:    result <= {sign, 31'h0};
                    default: result <= pack(sign, e, dp_rega);
                endcase
`else
                result <= pack(sign, e, dp_rega);
`endif
                out_valid <= 1'b1;
            end else if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
